// File: rtl/ptw_pkg.sv
// Shared definitions for the multi-level page-table walker: FSM state
// encoding, PTE flag bit positions and address-formation shifts.
package ptw_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } ptw_state_e;

    localparam int PTE_V           = 0;
    localparam int PTE_R           = 1;
    localparam int PTE_W           = 2;
    localparam int PTE_X           = 3;
    localparam int PPN_SHIFT       = 10;
    localparam int PTE_ENTRY_SHIFT = 2;

    // A PTE is a leaf when it is valid and grants at least one of R/W/X.
    function automatic logic pte_is_leaf(input logic [3:0] flags);
        return flags[PTE_V] & (flags[PTE_R] | flags[PTE_W] | flags[PTE_X]);
    endfunction

endpackage

// File: rtl/ptw_walk_cache.sv
// Single-entry walk cache: remembers the next-level table base for the most
// recent valid non-leaf root PTE, keyed by the root VPN. Only instantiated
// when PTW_WALK_CACHE_EN is defined.
module ptw_walk_cache #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned VPN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  fill_i,
    input  logic [VPN_WIDTH-1:0]  fill_vpn_i,
    input  logic [ADDR_WIDTH-1:0] fill_base_i,
    input  logic [VPN_WIDTH-1:0]  lookup_vpn_i,
    output logic                  hit_o,
    output logic [ADDR_WIDTH-1:0] base_o
);

    logic                  valid_q, valid_d;
    logic [VPN_WIDTH-1:0]  vpn_q, vpn_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;

    // Next-state: fill on a root non-leaf, flush overrides a same-cycle fill.
    always_comb begin
        valid_d = valid_q;
        vpn_d   = vpn_q;
        base_d  = base_q;
        if (fill_i) begin
            valid_d = 1'b1;
            vpn_d   = fill_vpn_i;
            base_d  = fill_base_i;
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            vpn_q   <= '0;
            base_q  <= '0;
        end else begin
            valid_q <= valid_d;
            vpn_q   <= vpn_d;
            base_q  <= base_d;
        end
    end

    assign hit_o  = valid_q && (vpn_q == lookup_vpn_i);
    assign base_o = base_q;

endmodule

// File: rtl/ptw_multilevel.sv
// Parametrised radix page-table walker between the TLB miss path and memory.
// One walk at a time, single outstanding memory read. Optional single-entry
// root walk cache enabled by defining PTW_WALK_CACHE_EN.
//
// Handshakes: every valid/ready pair transfers on a rising edge where both are
// high; a source holds valid and its payload stable until that edge, and a
// sink may raise or drop ready freely. All outputs here are registered.
module ptw_multilevel
    import ptw_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           PTE_WIDTH   = 32,
    parameter int unsigned           LEVELS      = 2,
    parameter int unsigned           VPN_WIDTH   = 10,
    parameter int unsigned           PAGE_OFFSET = 12,
    parameter logic [ADDR_WIDTH-1:0] ROOT_BASE   = 32'h400,
    localparam int unsigned          VA_W        = PAGE_OFFSET + LEVELS * VPN_WIDTH,
    localparam int unsigned          LVL_W       = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ptw_req_valid_i,
    output logic                  ptw_req_ready_o,
    input  logic [VA_W-1:0]       ptw_vaddr_i,
    input  logic                  ptw_flush_i,
    output logic                  ptw_resp_valid_o,
    input  logic                  ptw_resp_ready_i,
    output logic [PTE_WIDTH-1:0]  ptw_pte_o,
    output logic [LVL_W-1:0]      ptw_level_o,
    output logic                  ptw_fault_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_resp_valid_i,
    output logic                  mem_resp_ready_o,
    input  logic [PTE_WIDTH-1:0]  mem_data_i
);

    localparam logic [LVL_W-1:0] ROOT_LVL = LVL_W'(LEVELS - 1);
    localparam logic [LVL_W-1:0] SKIP_LVL = LVL_W'((LEVELS > 1) ? LEVELS - 2 : 0);

    ptw_state_e            state_q;
    logic [VA_W-1:0]       vaddr_q;
    logic [LVL_W-1:0]      walk_lvl_q;
    logic                  req_ready_q;
    logic                  mem_req_valid_q;
    logic                  mem_resp_ready_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  resp_valid_q;
    logic [PTE_WIDTH-1:0]  pte_q;
    logic [LVL_W-1:0]      level_q;
    logic                  fault_q;

    // VPN slice used to index the table at a given level.
    function automatic logic [VPN_WIDTH-1:0] vpn_at(input logic [VA_W-1:0] va,
                                                    input logic [LVL_W-1:0] lvl);
        logic [VA_W-1:0] s;
        s = va >> (PAGE_OFFSET + 32'(lvl) * VPN_WIDTH);
        return s[VPN_WIDTH-1:0];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] entry_addr(input logic [ADDR_WIDTH-1:0] base,
                                                         input logic [VPN_WIDTH-1:0]  vpn);
        return base + (ADDR_WIDTH'(vpn) << PTE_ENTRY_SHIFT);
    endfunction

    logic                  rsp_v;
    logic                  rsp_leaf;
    logic [ADDR_WIDTH-1:0] next_base;
    logic                  walk_fill;
    logic                  start_hit;
    logic [ADDR_WIDTH-1:0] cache_base;
    logic [LVL_W-1:0]      start_lvl;
    logic [ADDR_WIDTH-1:0] start_base;

    assign rsp_v     = mem_data_i[PTE_V];
    assign rsp_leaf  = pte_is_leaf(mem_data_i[3:0]);
    assign next_base = ADDR_WIDTH'({mem_data_i[PTE_WIDTH-1:PPN_SHIFT], {PPN_SHIFT{1'b0}}});
    // Root-level pointer PTE that is about to be followed.
    assign walk_fill = (state_q == S_WAIT) && mem_resp_valid_i && rsp_v && !rsp_leaf &&
                       (walk_lvl_q == ROOT_LVL) && (LEVELS > 1);

`ifdef PTW_WALK_CACHE_EN
    logic                 cache_hit;
    logic [VPN_WIDTH-1:0] fill_vpn;
    logic [VPN_WIDTH-1:0] lookup_vpn;

    assign fill_vpn   = vpn_at(vaddr_q, ROOT_LVL);
    assign lookup_vpn = vpn_at(ptw_vaddr_i, ROOT_LVL);

    ptw_walk_cache #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .VPN_WIDTH  (VPN_WIDTH)
    ) u_walk_cache (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (ptw_flush_i),
        .fill_i       (walk_fill),
        .fill_vpn_i   (fill_vpn),
        .fill_base_i  (next_base),
        .lookup_vpn_i (lookup_vpn),
        .hit_o        (cache_hit),
        .base_o       (cache_base)
    );

    assign start_hit = cache_hit && (LEVELS > 1);
`else
    logic unused_cfg;
    assign unused_cfg = ptw_flush_i ^ walk_fill;
    assign start_hit  = 1'b0;
    assign cache_base = '0;
`endif

    assign start_lvl  = start_hit ? SKIP_LVL : ROOT_LVL;
    assign start_base = start_hit ? cache_base : ROOT_BASE;

    // Walk FSM with all handshake and result outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            vaddr_q          <= '0;
            walk_lvl_q       <= '0;
            req_ready_q      <= 1'b1;
            mem_req_valid_q  <= 1'b0;
            mem_resp_ready_q <= 1'b0;
            mem_addr_q       <= '0;
            resp_valid_q     <= 1'b0;
            pte_q            <= '0;
            level_q          <= '0;
            fault_q          <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ptw_req_valid_i) begin
                        vaddr_q         <= ptw_vaddr_i;
                        walk_lvl_q      <= start_lvl;
                        mem_addr_q      <= entry_addr(start_base, vpn_at(ptw_vaddr_i, start_lvl));
                        req_ready_q     <= 1'b0;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_q  <= 1'b0;
                        mem_resp_ready_q <= 1'b1;
                        state_q          <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid_i) begin
                        mem_resp_ready_q <= 1'b0;
                        level_q          <= walk_lvl_q;
                        if (!rsp_v || (!rsp_leaf && walk_lvl_q == '0)) begin
                            pte_q        <= '0;
                            fault_q      <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else if (rsp_leaf) begin
                            pte_q        <= mem_data_i;
                            fault_q      <= 1'b0;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else begin
                            walk_lvl_q      <= walk_lvl_q - LVL_W'(1);
                            mem_addr_q      <= entry_addr(next_base,
                                                          vpn_at(vaddr_q, walk_lvl_q - LVL_W'(1)));
                            mem_req_valid_q <= 1'b1;
                            state_q         <= S_REQ;
                        end
                    end
                end
                S_RESP: begin
                    if (ptw_resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ptw_req_ready_o  = req_ready_q;
    assign ptw_resp_valid_o = resp_valid_q;
    assign ptw_pte_o        = pte_q;
    assign ptw_level_o      = level_q;
    assign ptw_fault_o      = fault_q;
    assign mem_req_valid_o  = mem_req_valid_q;
    assign mem_addr_o       = mem_addr_q;
    assign mem_resp_ready_o = mem_resp_ready_q;

endmodule

// File: tb/tb_ptw_multilevel.sv
// Bench for ptw_multilevel: behavioural memory, table-walk reference model
// (with walk-cache model when PTW_WALK_CACHE_EN is defined), directed and
// randomized walks.
module tb_ptw_multilevel;

  localparam int ADDR_WIDTH  = 32;
  localparam int PTE_WIDTH   = 32;
  localparam int LEVELS      = 2;
  localparam int VPN_WIDTH   = 10;
  localparam int PAGE_OFFSET = 12;
  localparam int VA_W        = PAGE_OFFSET + LEVELS * VPN_WIDTH;
  localparam int LVL_W       = 1;
  localparam logic [31:0] ROOT_BASE = 32'h400;

  logic                  clk;
  logic                  rst;
  logic                  ptw_req_valid_i;
  logic                  ptw_req_ready_o;
  logic [VA_W-1:0]       ptw_vaddr_i;
  logic                  ptw_flush_i;
  logic                  ptw_resp_valid_o;
  logic                  ptw_resp_ready_i;
  logic [PTE_WIDTH-1:0]  ptw_pte_o;
  logic [LVL_W-1:0]      ptw_level_o;
  logic                  ptw_fault_o;
  logic                  mem_req_valid_o;
  logic                  mem_req_ready_i;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_resp_valid_i;
  logic                  mem_resp_ready_o;
  logic [PTE_WIDTH-1:0]  mem_data_i;

  ptw_multilevel #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .PTE_WIDTH   (PTE_WIDTH),
    .LEVELS      (LEVELS),
    .VPN_WIDTH   (VPN_WIDTH),
    .PAGE_OFFSET (PAGE_OFFSET),
    .ROOT_BASE   (ROOT_BASE)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ptw_req_valid_i  (ptw_req_valid_i),
    .ptw_req_ready_o  (ptw_req_ready_o),
    .ptw_vaddr_i      (ptw_vaddr_i),
    .ptw_flush_i      (ptw_flush_i),
    .ptw_resp_valid_o (ptw_resp_valid_o),
    .ptw_resp_ready_i (ptw_resp_ready_i),
    .ptw_pte_o        (ptw_pte_o),
    .ptw_level_o      (ptw_level_o),
    .ptw_fault_o      (ptw_fault_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_addr_o       (mem_addr_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_ready_o (mem_resp_ready_o),
    .mem_data_i       (mem_data_i)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];   // expected memory addresses for the current walk
  logic [31:0] obs_q[$];   // addresses seen by the memory model
  logic [31:0] mem_a [logic [31:0]];
  bit          mem_stall = 1'b0;

  bit          m_cache_valid = 1'b0;
  logic [31:0] m_cache_vpn   = '0;
  logic [31:0] m_cache_base  = '0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_a.exists(a)) return mem_a[a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] va_vpn(input logic [31:0] va, input int lvl);
    return (va >> (PAGE_OFFSET + lvl * VPN_WIDTH)) & ((32'h1 << VPN_WIDTH) - 1);
  endfunction

  // Reference walk: follows the table rules directly over the memory image.
  task automatic model_walk(input logic [31:0] va, output logic [31:0] pte,
                            output int lvl, output bit flt);
    logic [31:0] base;
    logic [31:0] a;
    logic [31:0] d;
    int l;
    base = ROOT_BASE;
    l    = LEVELS - 1;
`ifdef PTW_WALK_CACHE_EN
    if (LEVELS > 1 && m_cache_valid && m_cache_vpn == va_vpn(va, LEVELS - 1)) begin
      base = m_cache_base;
      l    = LEVELS - 2;
    end
`endif
    pte = 0;
    flt = 1'b1;
    lvl = l;
    for (int step = 0; step < LEVELS; step++) begin
      a = base + 4 * va_vpn(va, l);
      exp_q.push_back(a);
      d   = mem_read(a);
      lvl = l;
      if (d[0] == 1'b0) begin pte = 0; flt = 1'b1; break; end
      if (d[3:1] != 3'b000) begin pte = d; flt = 1'b0; break; end
      if (l == 0) begin pte = 0; flt = 1'b1; break; end
      if (l == LEVELS - 1) begin
        m_cache_valid = 1'b1;
        m_cache_vpn   = va_vpn(va, l);
        m_cache_base  = (d / 1024) * 1024;
      end
      base = (d / 1024) * 1024;
      l    = l - 1;
    end
  endtask

  // ---------------- memory model (driver) ----------------
  initial begin
    bit          rst_seen;
    bit          req_fire_prev;
    bit          resp_fire_prev;
    bit          pend;
    int          dly;
    logic [31:0] addr_prev;
    logic [31:0] pend_addr;
    mem_req_ready_i  = 1'b1;
    mem_resp_valid_i = 1'b0;
    mem_data_i       = '0;
    req_fire_prev    = 1'b0;
    resp_fire_prev   = 1'b0;
    pend             = 1'b0;
    dly              = 0;
    addr_prev        = '0;
    pend_addr        = '0;
    forever begin
      @(posedge clk);
      rst_seen = rst;
      @(negedge clk);
      if (rst_seen) begin
        mem_resp_valid_i = 1'b0;
        mem_req_ready_i  = 1'b1;
        req_fire_prev    = 1'b0;
        resp_fire_prev   = 1'b0;
        pend             = 1'b0;
        continue;
      end
      if (resp_fire_prev) mem_resp_valid_i = 1'b0;
      if (req_fire_prev) begin
        pend      = 1'b1;
        dly       = mem_stall ? $urandom_range(0, 2) : 0;
        pend_addr = addr_prev;
        obs_q.push_back(addr_prev);
      end
      if (pend && !mem_resp_valid_i) begin
        if (dly == 0) begin
          mem_resp_valid_i = 1'b1;
          mem_data_i       = mem_read(pend_addr);
          pend             = 1'b0;
        end else begin
          dly = dly - 1;
        end
      end
      mem_req_ready_i = mem_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      req_fire_prev   = mem_req_valid_o && mem_req_ready_i;
      addr_prev       = mem_addr_o;
      resp_fire_prev  = mem_resp_valid_i && mem_resp_ready_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_flush();
    @(negedge clk);
    ptw_flush_i = 1'b1;
    @(negedge clk);
    ptw_flush_i = 1'b0;
`ifdef PTW_WALK_CACHE_EN
    m_cache_valid = 1'b0;
`endif
  endtask

  task automatic run_walk(input logic [31:0] va, input int hold, input string tag);
    logic [31:0] epte;
    int          elvl;
    bit          eflt;
    int          n_exp;
    int          k;
    bit          got;
    logic [31:0] spte;
    bit          sflt;
    bit          seq_ok;
    exp_q.delete();
    obs_q.delete();
    model_walk(va, epte, elvl, eflt);
    n_exp = exp_q.size();
    @(negedge clk);
    ptw_req_valid_i = 1'b1;
    ptw_vaddr_i     = va;
    got = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (ptw_req_ready_o) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      $display("FAIL %s accept: req_ready_o stayed %b, required 1", tag, ptw_req_ready_o);
      errors++;
      ptw_req_valid_i = 1'b0;
      return;
    end
    @(negedge clk);
    ptw_req_valid_i = 1'b0;
    ptw_vaddr_i     = $urandom;
    k   = 1;
    got = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (ptw_resp_valid_o) begin got = 1'b1; break; end
      @(negedge clk);
      k++;
    end
    checks++;
    if (!got) begin
      $display("FAIL %s resp_timeout: resp_valid_o never rose, required 1", tag);
      errors++;
      return;
    end
    if (!mem_stall) begin
      checks++;
      if (k !== 1 + 2 * n_exp) begin
        $display("FAIL %s latency: got %0d cycles, required %0d", tag, k, 1 + 2 * n_exp);
        errors++;
      end
    end
    spte = ptw_pte_o;
    sflt = ptw_fault_o;
    for (int h = 0; h < hold; h++) begin
      checks++;
      if (ptw_resp_valid_o !== 1'b1 || ptw_pte_o !== spte || ptw_fault_o !== sflt ||
          ptw_req_ready_o !== 1'b0) begin
        $display("FAIL %s hold: valid=%b pte=%h fault=%b req_ready=%b, required 1 %h %b 0",
                 tag, ptw_resp_valid_o, ptw_pte_o, ptw_fault_o, ptw_req_ready_o, spte, sflt);
        errors++;
      end
      @(negedge clk);
    end
    checks++;
    if (ptw_pte_o !== epte) begin
      $display("FAIL %s pte: got %h, required %h", tag, ptw_pte_o, epte);
      errors++;
    end
    checks++;
    if (ptw_fault_o !== eflt) begin
      $display("FAIL %s fault: got %b, required %b", tag, ptw_fault_o, eflt);
      errors++;
    end
    if (!eflt) begin
      checks++;
      if (ptw_level_o !== elvl[LVL_W-1:0]) begin
        $display("FAIL %s level: got %0d, required %0d", tag, ptw_level_o, elvl);
        errors++;
      end
    end
    ptw_resp_ready_i = 1'b1;
    @(negedge clk);
    ptw_resp_ready_i = 1'b0;
    checks++;
    if (ptw_req_ready_o !== 1'b1 || ptw_resp_valid_o !== 1'b0) begin
      $display("FAIL %s back_to_idle: req_ready=%b resp_valid=%b, required 1 0",
               tag, ptw_req_ready_o, ptw_resp_valid_o);
      errors++;
    end
    seq_ok = (obs_q.size() == exp_q.size());
    if (seq_ok) begin
      foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) seq_ok = 1'b0;
    end
    checks++;
    if (!seq_ok) begin
      $display("FAIL %s mem_addrs: got %p, required %p", tag, obs_q, exp_q);
      errors++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ptw_req_ready_o !== 1'b1 || mem_req_valid_o !== 1'b0 || mem_resp_ready_o !== 1'b0 ||
        ptw_resp_valid_o !== 1'b0 || ptw_pte_o !== '0 || ptw_fault_o !== 1'b0 ||
        mem_addr_o !== '0 || ptw_level_o !== '0) begin
      $display("FAIL reset_state: rr=%b mrv=%b mrr=%b rv=%b pte=%h flt=%b addr=%h, required 1 0 0 0 0 0 0",
               ptw_req_ready_o, mem_req_valid_o, mem_resp_ready_o, ptw_resp_valid_o,
               ptw_pte_o, ptw_fault_o, mem_addr_o);
      errors++;
    end
    rst = 1'b0;
    m_cache_valid = 1'b0;
  endtask

  task automatic test_directed();
    mem_stall = 1'b0;
    run_walk(32'h0000_1000, 0, "two_level");
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 32'h400 || obs_q[1] !== 32'h804) begin
      $display("FAIL two_level_addrs: got %p, required 400 804", obs_q);
      errors++;
    end
    run_walk(32'h0040_0000, 0, "superpage");
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 32'h404) begin
      $display("FAIL superpage_addrs: got %p, required 404", obs_q);
      errors++;
    end
    run_walk(32'h8000_0000, 0, "root_invalid_hi");
    run_walk(32'h0080_0000, 0, "root_invalid");
    run_walk(32'h0000_3000, 0, "leaf_invalid");
    run_walk(32'h0000_4000, 0, "nonleaf_level0");
    run_walk(32'h00C0_1000, 0, "second_table");
  endtask

  task automatic test_backpressure();
    mem_stall = 1'b0;
    run_walk(32'h0000_1000, 5, "backpressure");
  endtask

  task automatic test_reset_mid_walk();
    bit got;
    mem_stall = 1'b0;
    @(negedge clk);
    ptw_req_valid_i = 1'b1;
    ptw_vaddr_i     = 32'h0000_1000;
    got = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (ptw_req_ready_o) begin got = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    ptw_req_valid_i = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (mem_resp_ready_o) break;
      @(negedge clk);
    end
    checks++;
    if (!got || mem_resp_ready_o !== 1'b1) begin
      $display("FAIL mid_walk_reach_wait: mem_resp_ready_o=%b, required 1", mem_resp_ready_o);
      errors++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_cache_valid = 1'b0;
    checks++;
    if (ptw_req_ready_o !== 1'b1 || mem_req_valid_o !== 1'b0 || mem_resp_ready_o !== 1'b0 ||
        ptw_resp_valid_o !== 1'b0 || ptw_fault_o !== 1'b0 || ptw_pte_o !== '0) begin
      $display("FAIL mid_walk_reset: rr=%b mrv=%b mrr=%b rv=%b, required 1 0 0 0",
               ptw_req_ready_o, mem_req_valid_o, mem_resp_ready_o, ptw_resp_valid_o);
      errors++;
    end
    run_walk(32'h0000_0000, 0, "after_reset");
    checks++;
    if (ptw_pte_o !== 32'h1000_000F) begin
      $display("FAIL after_reset_pte: got %h, required 1000000f", ptw_pte_o);
      errors++;
    end
  endtask

`ifdef PTW_WALK_CACHE_EN
  task automatic test_walk_cache();
    mem_stall = 1'b0;
    do_flush();
    run_walk(32'h0000_0000, 0, "cache_fill");
    run_walk(32'h0000_2000, 0, "cache_hit");
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 32'h808 || ptw_pte_o !== 32'h1200_0007) begin
      $display("FAIL cache_hit_direct: addrs %p pte %h, required 808 12000007", obs_q, ptw_pte_o);
      errors++;
    end
    do_flush();
    run_walk(32'h0000_2000, 0, "cache_flushed");
    checks++;
    if (obs_q.size() == 0 || obs_q[0] !== 32'h400) begin
      $display("FAIL cache_flushed_direct: addrs %p, required first 400", obs_q);
      errors++;
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] va;
    logic [31:0] top;
    for (int n = 0; n < 40; n++) begin
      mem_stall = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 4))
        0: top = 32'd0;
        1: top = 32'd1;
        2: top = 32'd2;
        3: top = 32'd3;
        default: top = $urandom_range(0, 1023);
      endcase
      va = (top << 22) | (32'($urandom_range(0, 5)) << 12) | 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 7) == 0) do_flush();
      run_walk(va, $urandom_range(0, 3), "random");
    end
    mem_stall = 1'b0;
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst              = 1'b1;
    ptw_req_valid_i  = 1'b0;
    ptw_vaddr_i      = '0;
    ptw_flush_i      = 1'b0;
    ptw_resp_ready_i = 1'b0;
    mem_a[32'h400] = 32'h0000_0801;
    mem_a[32'h404] = 32'h1234_0007;
    mem_a[32'h408] = 32'h0000_0000;
    mem_a[32'h40C] = 32'h0000_1401;
    mem_a[32'h800] = 32'h1000_000F;
    mem_a[32'h804] = 32'h1100_000F;
    mem_a[32'h808] = 32'h1200_0007;
    mem_a[32'h80C] = 32'h0000_0000;
    mem_a[32'h810] = 32'h0000_0001;
    mem_a[32'h1400] = 32'h2000_000B;
    mem_a[32'h1404] = 32'h2100_0003;
    mem_a[32'h1408] = 32'h0000_0C01;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_walk();
`ifdef PTW_WALK_CACHE_EN
    test_walk_cache();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
